// File: rtl/pipe_ctrl.sv
// Pipeline control for the RV32I core: owns the PC and produces per-register stall/flush
// vectors from jump, load-use, multi-cycle EX and external hold conditions.
module pipe_ctrl #(
   parameter int          XLEN     = 32,
   parameter int          NSTAGE   = 4,
   parameter logic [31:0] RST_PC   = 32'h0,
   parameter logic [31:0] TRAP_VEC = 32'h0000_0100,
   parameter int          MAX_BUSY = 64,
   parameter int          CNT_W    = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              jump_en_i,
   input  logic [XLEN-1:0]   jump_addr_i,
   input  logic              ex_busy_i,
   input  logic              ext_hold_i,
   input  logic [4:0]        id_rs1_addr_i,
   input  logic [4:0]        id_rs2_addr_i,
   input  logic              id_rs1_used_i,
   input  logic              id_rs2_used_i,
   input  logic [4:0]        ex_rd_addr_i,
   input  logic              ex_rd_wen_i,
   input  logic              ex_is_load_i,
   output logic [XLEN-1:0]   pc_o,
   output logic [NSTAGE-1:0] stall_o,
   output logic [NSTAGE-1:0] flush_o,
   output logic              trap_o,
   output logic [XLEN-1:0]   trap_pc_o,
   output logic              busy_timeout_o,
   output logic [CNT_W-1:0]  stall_cycles_o
);

   localparam int BW = $clog2(MAX_BUSY + 1);
   localparam logic [BW-1:0] BUSY_MAX = BW'(MAX_BUSY);

   // Bit masks sized to NSTAGE; bit 2 drops out by truncation when NSTAGE == 2.
   localparam logic [NSTAGE-1:0] M_IF_ID  = NSTAGE'(1);
   localparam logic [NSTAGE-1:0] M_ID_EX  = NSTAGE'(2);
   localparam logic [NSTAGE-1:0] M_FRONT  = NSTAGE'(3);
   localparam logic [NSTAGE-1:0] M_EX_MEM = NSTAGE'(4);

   typedef enum logic {ST_RUN = 1'b0, ST_BUSY = 1'b1} state_e;

   state_e            state_q;
   logic [BW-1:0]     busy_cnt_q;
   logic [BW-1:0]     busy_cnt_inc;
   logic              busy_timeout_q;
   logic [XLEN-1:0]   pc_q, pc_d;
   logic              trap_q, trap_d;
   logic [XLEN-1:0]   trap_pc_q, trap_pc_d;
   logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;

   logic load_use;
   logic case_hold, case_busy, case_jump, case_lu;
   logic pc_hold;
   logic jump_misal;

   always_comb begin
      load_use = ex_is_load_i && ex_rd_wen_i && (ex_rd_addr_i != 5'd0) &&
                 ((id_rs1_used_i && (id_rs1_addr_i == ex_rd_addr_i)) ||
                  (id_rs2_used_i && (id_rs2_addr_i == ex_rd_addr_i)));

      case_hold = ext_hold_i;
      case_busy = !ext_hold_i && ex_busy_i;
      case_jump = !ext_hold_i && !ex_busy_i && jump_en_i;
      case_lu   = !ext_hold_i && !ex_busy_i && !jump_en_i && load_use;
      pc_hold   = case_hold || case_busy || case_lu;

      stall_o = '0;
      flush_o = '0;
      if (case_hold) begin
         stall_o = '1;
      end else if (case_busy) begin
         stall_o = M_FRONT;
         flush_o = M_EX_MEM;
      end else if (case_jump) begin
         flush_o = M_FRONT;
      end else if (case_lu) begin
         stall_o = M_IF_ID;
         flush_o = M_ID_EX;
      end

      jump_misal = |jump_addr_i[1:0];
      pc_d       = pc_q;
      if (case_jump) begin
         pc_d = jump_misal ? XLEN'(TRAP_VEC) : jump_addr_i;
      end else if (!pc_hold) begin
         pc_d = pc_q + XLEN'(4);
      end

      trap_d    = case_jump && jump_misal;
      trap_pc_d = trap_d ? jump_addr_i : trap_pc_q;

      stall_cnt_d  = pc_hold ? stall_cnt_q + CNT_W'(1) : stall_cnt_q;
      busy_cnt_inc = (busy_cnt_q >= BUSY_MAX) ? busy_cnt_q : busy_cnt_q + BW'(1);
   end

   // The cycle that enters BUSY is itself counted, so the count equals held EX cycles.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q        <= ST_RUN;
         busy_cnt_q     <= '0;
         busy_timeout_q <= 1'b0;
         pc_q           <= XLEN'(RST_PC);
         trap_q         <= 1'b0;
         trap_pc_q      <= '0;
         stall_cnt_q    <= '0;
      end else begin
         pc_q        <= pc_d;
         trap_q      <= trap_d;
         trap_pc_q   <= trap_pc_d;
         stall_cnt_q <= stall_cnt_d;
         case (state_q)
            ST_RUN: begin
               if (case_busy) begin
                  state_q    <= ST_BUSY;
                  busy_cnt_q <= BW'(1);
                  if (BW'(1) >= BUSY_MAX) busy_timeout_q <= 1'b1;
               end
            end
            ST_BUSY: begin
               if (ext_hold_i) begin
                  state_q <= ST_BUSY;
               end else if (ex_busy_i) begin
                  busy_cnt_q <= busy_cnt_inc;
                  if (busy_cnt_inc >= BUSY_MAX) busy_timeout_q <= 1'b1;
               end else begin
                  state_q <= ST_RUN;
               end
            end
            default: state_q <= ST_RUN;
         endcase
      end
   end

   assign pc_o           = pc_q;
   assign trap_o         = trap_q;
   assign trap_pc_o      = trap_pc_q;
   assign busy_timeout_o = busy_timeout_q;
   assign stall_cycles_o = stall_cnt_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: each driven cycle pushes its hand-computed expected
// observation; a negedge monitor pops and compares against the DUT.
module tb_pipe_ctrl;

   typedef struct packed {
      logic [31:0] pc;
      logic [3:0]  stall;
      logic [3:0]  flush;
      logic        trap;
      logic [31:0] trap_pc;
      logic        tmo;
      logic [31:0] sc;
   } obs_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        jump_en = 1'b0;
   logic [31:0] jump_addr = '0;
   logic        ex_busy = 1'b0;
   logic        ext_hold = 1'b0;
   logic [4:0]  rs1 = '0, rs2 = '0, rd = '0;
   logic        rs1_used = 1'b0, rs2_used = 1'b0, rd_wen = 1'b0, is_load = 1'b0;
   logic [31:0] pc;
   logic [3:0]  stall, flush;
   logic        trap, tmo;
   logic [31:0] trap_pc, sc;

   obs_t exp_q[$];
   logic obs_v = 1'b0;
   int   total = 0;
   int   bad = 0;

   pipe_ctrl #(.XLEN(32), .NSTAGE(4), .RST_PC(32'h0), .TRAP_VEC(32'h100),
               .MAX_BUSY(8), .CNT_W(32)) dut (
      .clk(clk), .rst(rst),
      .jump_en_i(jump_en), .jump_addr_i(jump_addr),
      .ex_busy_i(ex_busy), .ext_hold_i(ext_hold),
      .id_rs1_addr_i(rs1), .id_rs2_addr_i(rs2),
      .id_rs1_used_i(rs1_used), .id_rs2_used_i(rs2_used),
      .ex_rd_addr_i(rd), .ex_rd_wen_i(rd_wen), .ex_is_load_i(is_load),
      .pc_o(pc), .stall_o(stall), .flush_o(flush),
      .trap_o(trap), .trap_pc_o(trap_pc),
      .busy_timeout_o(tmo), .stall_cycles_o(sc)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Monitor: one expected observation per driven cycle.
   always @(negedge clk) begin
      if (obs_v) begin
         if (exp_q.size() == 0) begin
            chk("queue_underflow", 32'd1, 32'd0);
         end else begin
            obs_t e;
            e = exp_q.pop_front();
            chk("pc", pc, e.pc);
            chk("stall", {28'd0, stall}, {28'd0, e.stall});
            chk("flush", {28'd0, flush}, {28'd0, e.flush});
            chk("trap", {31'd0, trap}, {31'd0, e.trap});
            chk("trap_pc", trap_pc, e.trap_pc);
            chk("busy_timeout", {31'd0, tmo}, {31'd0, e.tmo});
            chk("stall_cycles", sc, e.sc);
         end
      end
   end

   task automatic set_hz(input logic [4:0] a1, input logic u1, input logic [4:0] a2,
                         input logic u2, input logic [4:0] d, input logic w, input logic ld);
      rs1 = a1; rs1_used = u1; rs2 = a2; rs2_used = u2; rd = d; rd_wen = w; is_load = ld;
   endtask

   // Drive one cycle of inputs and queue what the DUT must show during that cycle.
   task automatic step(input logic r, input logic j, input logic [31:0] ja, input logic b,
                       input logic h, input logic [31:0] e_pc, input logic [3:0] e_st,
                       input logic [3:0] e_fl, input logic e_tr, input logic [31:0] e_tpc,
                       input logic e_to, input logic [31:0] e_sc);
      obs_t e;
      rst = r; jump_en = j; jump_addr = ja; ex_busy = b; ext_hold = h;
      e = '{pc: e_pc, stall: e_st, flush: e_fl, trap: e_tr, trap_pc: e_tpc, tmo: e_to, sc: e_sc};
      exp_q.push_back(e);
      obs_v = 1'b1;
      @(posedge clk);
      #1;
      obs_v = 1'b0;
      set_hz(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
   endtask

   initial begin
      repeat (2) @(posedge clk);
      #1;
      // free running and reset state
      step(0, 0, 0,     0, 0, 32'h0,  4'b0000, 4'b0000, 0, 0, 0, 0);
      step(0, 0, 0,     0, 0, 32'h4,  4'b0000, 4'b0000, 0, 0, 0, 0);
      // aligned then misaligned jump
      step(0, 1, 32'h80, 0, 0, 32'h8,  4'b0000, 4'b0011, 0, 0, 0, 0);
      step(0, 1, 32'h82, 0, 0, 32'h80, 4'b0000, 4'b0011, 0, 0, 0, 0);
      step(0, 0, 0,     0, 0, 32'h100, 4'b0000, 4'b0000, 1, 32'h82, 0, 0);
      // load-use on rs1
      set_hz(5'd5, 1, 5'd0, 0, 5'd5, 1, 1);
      step(0, 0, 0,     0, 0, 32'h104, 4'b0001, 4'b0010, 0, 32'h82, 0, 0);
      step(0, 0, 0,     0, 0, 32'h104, 4'b0000, 4'b0000, 0, 32'h82, 0, 1);
      // no hazard: rd=0, unused source, no write enable
      set_hz(5'd0, 1, 5'd0, 0, 5'd0, 1, 1);
      step(0, 0, 0,     0, 0, 32'h108, 4'b0000, 4'b0000, 0, 32'h82, 0, 1);
      set_hz(5'd5, 0, 5'd6, 1, 5'd5, 1, 1);
      step(0, 0, 0,     0, 0, 32'h10C, 4'b0000, 4'b0000, 0, 32'h82, 0, 1);
      set_hz(5'd0, 0, 5'd6, 1, 5'd6, 0, 1);
      step(0, 0, 0,     0, 0, 32'h110, 4'b0000, 4'b0000, 0, 32'h82, 0, 1);
      // load-use on rs2 loses to a jump
      set_hz(5'd0, 0, 5'd6, 1, 5'd6, 1, 1);
      step(0, 1, 32'h40, 0, 0, 32'h114, 4'b0000, 4'b0011, 0, 32'h82, 0, 1);
      // ten busy cycles, jump ignored in the third; timeout visible after the 8th
      for (int k = 1; k <= 10; k++) begin
         step(0, (k == 3), 32'h200, 1, 0, 32'h40, 4'b0011, 4'b0100, 0, 32'h82,
              (k >= 9), 32'(k));
      end
      step(0, 0, 0,     0, 0, 32'h40, 4'b0000, 4'b0000, 0, 32'h82, 1, 11);
      // external hold over jump and busy, jump taken once hold drops
      step(0, 1, 32'h300, 1, 1, 32'h44, 4'b1111, 4'b0000, 0, 32'h82, 1, 11);
      step(0, 1, 32'h300, 1, 1, 32'h44, 4'b1111, 4'b0000, 0, 32'h82, 1, 12);
      step(0, 1, 32'h300, 0, 0, 32'h44, 4'b0000, 4'b0011, 0, 32'h82, 1, 13);
      step(0, 0, 0,     0, 0, 32'h300, 4'b0000, 4'b0000, 0, 32'h82, 1, 13);
      // hold while in BUSY
      step(0, 0, 0,     1, 0, 32'h304, 4'b0011, 4'b0100, 0, 32'h82, 1, 13);
      step(0, 0, 0,     1, 1, 32'h304, 4'b1111, 4'b0000, 0, 32'h82, 1, 14);
      step(0, 0, 0,     1, 0, 32'h304, 4'b0011, 4'b0100, 0, 32'h82, 1, 15);
      step(0, 0, 0,     0, 0, 32'h304, 4'b0000, 4'b0000, 0, 32'h82, 1, 16);
      // PC wrap-around
      step(0, 1, 32'hFFFF_FFFC, 0, 0, 32'h308, 4'b0000, 4'b0011, 0, 32'h82, 1, 16);
      step(0, 0, 0,     0, 0, 32'hFFFF_FFFC, 4'b0000, 4'b0000, 0, 32'h82, 1, 16);
      step(0, 0, 0,     0, 0, 32'h0, 4'b0000, 4'b0000, 0, 32'h82, 1, 16);
      // five busy cycles, then asynchronous reset mid-BUSY
      for (int k = 0; k < 5; k++) begin
         step(0, 0, 0, 1, 0, 32'h4, 4'b0011, 4'b0100, 0, 32'h82, 1, 32'(16 + k));
      end
      step(1, 0, 0,     1, 0, 32'h0, 4'b0011, 4'b0100, 0, 0, 0, 0);
      step(0, 0, 0,     0, 0, 32'h0, 4'b0000, 4'b0000, 0, 0, 0, 0);
      step(0, 0, 0,     0, 0, 32'h4, 4'b0000, 4'b0000, 0, 0, 0, 0);
      repeat (2) @(posedge clk);
      chk("queue_drained", 32'(exp_q.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
